// File: rtl/stim_recorder.sv
// Stimulus trace recorder: captures {out, obs, data} samples into a small RAM,
// then replays them once over a valid/ready readout port.
module stim_recorder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int REC_W = DATA_W + 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              cap_obs,
    input  logic              cap_out,
    input  logic              dump_req,
    input  logic              clear,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [REC_W-1:0]  rd_data,
    output logic [AW-1:0]     rd_idx,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DUMP, DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t            state, state_nxt;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [AW:0]       rd_ptr;
    logic              cap_take;
    logic              wr_en;
    logic              rd_fire;
    logic              last_fire;

    // dump_req outranks cap_en, so a sample on the dump edge is never stored
    assign cap_take  = (state == IDLE || state == CAPTURE) && !dump_req && cap_en;
    assign wr_en     = cap_take && (count != DEPTH_C);
    assign rd_valid  = (state == DUMP) && (count != '0);
    assign rd_fire   = rd_valid && rd_ready;
    assign last_fire = rd_fire && (rd_ptr == count - ONE_C);
    assign done      = (state == DONE);
    assign rd_idx    = rd_ptr[AW-1:0];
    assign rd_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dump_req)    state_nxt = DUMP;
                else if (cap_en) state_nxt = CAPTURE;
            end
            CAPTURE: if (dump_req) state_nxt = DUMP;
            DUMP: begin
                if (count == '0 || last_fire) state_nxt = DONE;
            end
            DONE: if (clear) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
            rd_ptr   <= '0;
        end else begin
            if (wr_en) count <= count + ONE_C;
            if (cap_take && count == DEPTH_C) overflow <= 1'b1;
            if (state != DUMP && state_nxt == DUMP) rd_ptr <= '0;
            // pointer is one bit wider than the index so it never wraps to a stale entry
            if (rd_fire) rd_ptr <= rd_ptr + ONE_C;
            if (state == DONE && clear) begin
                count    <= '0;
                overflow <= 1'b0;
                rd_ptr   <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[count[AW-1:0]] <= {cap_out, cap_obs, cap_data};
    end

endmodule

// File: tb/tb_stim_recorder.sv
// Bench for stim_recorder: a 16-deep and a 4-deep instance share stimulus and are
// checked against a queue-style trace model, a vector table and directed corner cases.
module tb_stim_recorder;

    logic       clock, reset;
    logic       cap_en, cap_obs, cap_out, dump_req, clear, rd_ready;
    logic [7:0] cap_data;

    logic       rd_valid16, ovf16, done16;
    logic [9:0] rd_data16;
    logic [3:0] rd_idx16;
    logic [4:0] count16;

    logic       rd_valid4, ovf4, done4;
    logic [9:0] rd_data4;
    logic [1:0] rd_idx4;
    logic [2:0] count4;

    stim_recorder #(.DATA_W(8), .DEPTH(16)) u16 (
        .clock(clock), .reset(reset), .cap_en(cap_en), .cap_data(cap_data),
        .cap_obs(cap_obs), .cap_out(cap_out), .dump_req(dump_req), .clear(clear),
        .rd_valid(rd_valid16), .rd_ready(rd_ready), .rd_data(rd_data16),
        .rd_idx(rd_idx16), .count(count16), .overflow(ovf16), .done(done16)
    );

    stim_recorder #(.DATA_W(8), .DEPTH(4)) u4 (
        .clock(clock), .reset(reset), .cap_en(cap_en), .cap_data(cap_data),
        .cap_obs(cap_obs), .cap_out(cap_out), .dump_req(dump_req), .clear(clear),
        .rd_valid(rd_valid4), .rd_ready(rd_ready), .rd_data(rd_data4),
        .rd_idx(rd_idx4), .count(count4), .overflow(ovf4), .done(done4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase of the recorder plus the list of kept samples.
    localparam int M_IDLE = 0, M_CAP = 1, M_DUMP = 2, M_DONE = 3;
    int         m_mode [2];
    int         m_cnt  [2];
    int         m_ptr  [2];
    bit         m_ovf  [2];
    logic [9:0] m_mem  [2][16];
    int         m_dep  [2] = '{16, 4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE;
            m_cnt[k]  = 0;
            m_ptr[k]  = 0;
            m_ovf[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            case (m_mode[k])
                M_IDLE, M_CAP: begin
                    if (dump_req) begin
                        m_mode[k] = M_DUMP;
                        m_ptr[k]  = 0;
                    end else if (cap_en) begin
                        m_mode[k] = M_CAP;
                        if (m_cnt[k] < m_dep[k]) begin
                            m_mem[k][m_cnt[k]] = {cap_out, cap_obs, cap_data};
                            m_cnt[k]++;
                        end else begin
                            m_ovf[k] = 1'b1;
                        end
                    end
                end
                M_DUMP: begin
                    if (m_cnt[k] == 0) m_mode[k] = M_DONE;
                    else if (rd_ready) begin
                        if (m_ptr[k] == m_cnt[k] - 1) m_mode[k] = M_DONE;
                        m_ptr[k]++;
                    end
                end
                default: begin
                    if (clear) begin
                        m_cnt[k]  = 0;
                        m_ovf[k]  = 1'b0;
                        m_ptr[k]  = 0;
                        m_mode[k] = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic check_dut(input int k);
        logic        v, o, dn, ev;
        logic [9:0]  d;
        logic [31:0] idx, cnt;
        string       p;
        p = (k == 0) ? "u16" : "u4";
        if (k == 0) begin
            v = rd_valid16; o = ovf16; dn = done16; d = rd_data16;
            idx = 32'(rd_idx16); cnt = 32'(count16);
        end else begin
            v = rd_valid4; o = ovf4; dn = done4; d = rd_data4;
            idx = 32'(rd_idx4); cnt = 32'(count4);
        end
        ev = (m_mode[k] == M_DUMP) && (m_cnt[k] > 0);
        chk({p, ".count"},    cnt,      32'(m_cnt[k]));
        chk({p, ".overflow"}, 32'(o),   32'(m_ovf[k]));
        chk({p, ".done"},     32'(dn),  32'(m_mode[k] == M_DONE));
        chk({p, ".rd_valid"}, 32'(v),   32'(ev));
        if (ev) begin
            chk({p, ".rd_idx"},  idx,   32'(m_ptr[k]));
            chk({p, ".rd_data"}, 32'(d), 32'(m_mem[k][m_ptr[k]]));
        end
    endtask

    task automatic check_all();
        check_dut(0);
        check_dut(1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        cap_en = 0; cap_data = 0; cap_obs = 0; cap_out = 0;
        dump_req = 0; clear = 0; rd_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("reset.rd_idx16", 32'(rd_idx16), 32'd0);
        chk("reset.rd_idx4",  32'(rd_idx4),  32'd0);
        @(posedge clock);
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic write(input logic [7:0] d, input logic obs, input logic out);
        cap_en = 1; cap_data = d; cap_obs = obs; cap_out = out;
        tick();
        cap_en = 0;
    endtask

    task automatic drain_and_clear(input string name);
        int cyc;
        rd_ready = 1; cyc = 0;
        while (!(done16 && done4) && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!(done16 && done4)) chk({name, ".drain_timeout"}, 32'd1, 32'd0);
        rd_ready = 0; clear = 1;
        tick();
        clear = 0;
    endtask

    typedef struct {
        logic       cap_en;
        logic [7:0] data;
        logic       obs;
        logic       out;
        logic       dump_req;
        logic       clear;
        logic       rd_ready;
        int         e_count;
        logic       e_valid;
        int         e_idx;
        logic [9:0] e_data;
        logic       e_done;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] first;
        int         seen, cyc;

        tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 10'h000, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0, 10'h000, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 10'h000, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b1, 0, 10'h111, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1, 10'h222, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 2, 10'h133, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0, 10'h000, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 10'h000, 1'b0};

        set_idle();
        do_reset();

        // basic capture and dump, table-driven against the 16-deep instance
        for (int i = 0; i < 8; i++) begin
            cap_en = tbl[i].cap_en; cap_data = tbl[i].data; cap_obs = tbl[i].obs;
            cap_out = tbl[i].out; dump_req = tbl[i].dump_req; clear = tbl[i].clear;
            rd_ready = tbl[i].rd_ready;
            tick();
            chk($sformatf("tbl%0d.count", i),    32'(count16),    32'(tbl[i].e_count));
            chk($sformatf("tbl%0d.rd_valid", i), 32'(rd_valid16), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.done", i),     32'(done16),     32'(tbl[i].e_done));
            chk($sformatf("tbl%0d.overflow", i), 32'(ovf16),      32'd0);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d.rd_idx", i),  32'(rd_idx16),  32'(tbl[i].e_idx));
                chk($sformatf("tbl%0d.rd_data", i), 32'(rd_data16), 32'(tbl[i].e_data));
            end
        end
        set_idle();

        // overflow on the 4-deep instance
        for (int i = 1; i <= 6; i++) write(8'(i), 1'b0, 1'b0);
        chk("ovf.count4", 32'(count4), 32'd4);
        chk("ovf.flag4",  32'(ovf4),   32'd1);
        chk("ovf.count16", 32'(count16), 32'd6);
        chk("ovf.flag16",  32'(ovf16),   32'd0);
        dump_req = 1; tick(); dump_req = 0;
        rd_ready = 1; seen = 0; cyc = 0;
        while (!(done16 && done4) && cyc < 40) begin
            if (rd_valid4) begin
                chk("ovf.dump_data4", 32'(rd_data4), 32'(seen + 1));
                seen++;
            end
            tick();
            cyc++;
        end
        chk("ovf.entries4", 32'(seen), 32'd4);
        chk("ovf.done_seen", 32'(done16 && done4), 32'd1);
        rd_ready = 0; clear = 1; tick(); clear = 0;
        chk("ovf.cleared_flag4",  32'(ovf4),   32'd0);
        chk("ovf.cleared_count4", 32'(count4), 32'd0);

        // backpressure holds the first entry steady
        first = {1'b1, 1'b0, 8'(32'h5A)};
        write(8'h5A, 1'b0, 1'b1);
        write(8'(32'($urandom_range(0, 255))), 1'b1, 1'b1);
        write(8'(32'($urandom_range(0, 255))), 1'b0, 1'b0);
        dump_req = 1; tick(); dump_req = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.rd_valid", 32'(rd_valid16), 32'd1);
            chk("bp.rd_idx",   32'(rd_idx16),   32'd0);
            chk("bp.rd_data",  32'(rd_data16),  32'(first));
        end
        rd_ready = 1; tick();
        chk("bp.resume_idx", 32'(rd_idx16), 32'd1);
        drain_and_clear("bp");

        // empty dump
        dump_req = 1; tick(); dump_req = 0;
        chk("empty.valid_in_dump", 32'(rd_valid16), 32'd0);
        chk("empty.not_done_yet",  32'(done16),     32'd0);
        tick();
        chk("empty.done",  32'(done16),     32'd1);
        chk("empty.valid", 32'(rd_valid16), 32'd0);
        chk("empty.count", 32'(count16),    32'd0);
        clear = 1; tick(); clear = 0;

        // dump_req beats cap_en on the same edge
        write(8'hA1, 1'b0, 1'b0);
        write(8'hA2, 1'b1, 1'b0);
        cap_en = 1; cap_data = 8'hA3; dump_req = 1;
        tick();
        set_idle();
        chk("prio.count",    32'(count16),    32'd2);
        chk("prio.rd_valid", 32'(rd_valid16), 32'd1);
        drain_and_clear("prio");
        chk("prio.clear_count", 32'(count16), 32'd0);
        chk("prio.clear_ovf",   32'(ovf16),   32'd0);

        // asynchronous reset in the middle of a dump
        write(8'hC1, 1'b1, 1'b1);
        write(8'hC2, 1'b1, 1'b1);
        write(8'hC3, 1'b1, 1'b1);
        dump_req = 1; tick(); dump_req = 0;
        rd_ready = 1; tick(); rd_ready = 0;
        chk("rst.pre_idx", 32'(rd_idx16), 32'd1);
        #2;
        do_reset();
        dump_req = 1; tick(); dump_req = 0;
        chk("rst.count_after", 32'(count16), 32'd0);
        tick();
        chk("rst.done_after", 32'(done16), 32'd1);
        clear = 1; tick(); clear = 0;

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            cap_en   = ($urandom_range(0, 9) < 6);
            cap_data = 8'($urandom_range(0, 255));
            cap_obs  = 1'($urandom_range(0, 1));
            cap_out  = 1'($urandom_range(0, 1));
            dump_req = ($urandom_range(0, 19) == 0);
            clear    = ($urandom_range(0, 3) == 0);
            rd_ready = 1'($urandom_range(0, 1));
            if (i == 400) begin
                set_idle();
                do_reset();
            end else begin
                tick();
            end
        end
        set_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
